seq_alu: RTL and testbench

//   Parametrised, registered successor to the combinational 64-bit datapath ALU. It adds a

---
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_alu.sv | 141 ++++++++++++++
 tb/tb_seq_alu.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the EX-stage operand muxes and seq_alu.
//   in_valid/in_ready   : operand handshake (A, B, cntrl travel with it)
//   out_valid/out_ready : result handshake (result, NZVC flags travel with it)
//   master : operand producer / result consumer
//   slave  : the ALU
interface seq_alu_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output in_valid, A, B, cntrl, out_ready,
        input  in_ready, out_valid, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  in_valid, A, B, cntrl, out_ready,
        output in_ready, out_valid, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, LSL and an iterative shift-add multiply.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : seq_alu_if.slave (operands/cntrl in, result and NZVC flags out)
// Single-cycle ops complete on the accept edge; MUL retires MUL_STEP multiplier
// bits per cycle and completes WIDTH/MUL_STEP edges after accept.
module seq_alu #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned STEPS = WIDTH / MUL_STEP;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] mul_next;

    // Ready depends on out_ready so a DONE result can hand over to a new op in the same edge.
    assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid & bus.in_ready;

    // Single-cycle datapath; SUB is A + ~B + 1 so carry means "no borrow".
    always_comb begin
        b_eff   = (bus.cntrl == OP_SUB) ? ~bus.B : bus.B;
        sum     = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (bus.cntrl == OP_SUB)};
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (bus.cntrl)
            OP_PASS: alu_res = bus.B;
            OP_LSL:  alu_res = bus.A << bus.B[SHW-1:0];
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.A[MSB] == b_eff[MSB]) & (sum[MSB] != bus.A[MSB]);
            end
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            default: alu_res = '0;
        endcase
    end

    // Partial product for the MUL_STEP low multiplier bits of this iteration.
    always_comb begin
        part = '0;
        for (int i = 0; i < int'(MUL_STEP); i++) begin
            if (mplier[i]) begin
                part = part + (mcand << i);
            end
        end
        mul_next = acc + part;
    end

    // Control FSM and registered result/flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.result    <= '0;
            bus.negative  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.carry_out <= 1'b0;
        end else if (accept) begin
            if (bus.cntrl == OP_MUL) begin
                state  <= MUL;
                mcand  <= bus.A;
                mplier <= bus.B;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                state         <= DONE;
                bus.result    <= alu_res;
                bus.negative  <= alu_res[MSB];
                bus.zero      <= (alu_res == '0);
                bus.overflow  <= alu_v;
                bus.carry_out <= alu_c;
            end
        end else begin
            case (state)
                MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state         <= DONE;
                        bus.result    <= mul_next;
                        bus.negative  <= mul_next[MSB];
                        bus.zero      <= (mul_next == '0);
                        bus.overflow  <= 1'b0;
                        bus.carry_out <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int unsigned W = 64;

    typedef struct packed {
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu_if #(.WIDTH(W)) bus4 ();

    seq_alu #(.WIDTH(W), .MUL_STEP(1)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
    seq_alu #(.WIDTH(W), .MUL_STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    int vectors     = 0;
    int miscompares = 0;
    int checks      = 0;
    int cyc_cnt     = 0;
    logic rand_rdy  = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic signed [64:0] s;
        logic [64:0] u;
        e = '0;
        s = '0;
        u = '0;
        case (op)
            3'd0: e.r = b;
            3'd1: e.r = a << b[5:0];
            3'd2: begin
                u   = {1'b0, a} + {1'b0, b};
                e.r = u[63:0];
                e.c = u[64];
                s   = $signed({a[63], a}) + $signed({b[63], b});
                e.v = (s[64] != s[63]);
            end
            3'd3: begin
                e.r = a - b;
                e.c = (a >= b);
                s   = $signed({a[63], a}) - $signed({b[63], b});
                e.v = (s[64] != s[63]);
            end
            3'd4: e.r = a & b;
            3'd5: e.r = a | b;
            3'd6: e.r = a ^ b;
            default: e.r = a * b;
        endcase
        e.n = e.r[63];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Cycle-level behavioural model plus the per-cycle compare.
    logic  m_valid;
    logic  m_ready;
    int    m_busy;
    exp_t  m_out;
    exp_t  m_pend;
    initial begin
        m_valid = 1'b0;
        m_busy  = 0;
        m_out   = '0;
        m_pend  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_valid = 1'b0;
                m_busy  = 0;
                m_out   = '0;
            end
            m_ready = (m_busy == 0) && (!m_valid || bus.out_ready);
            check("in_ready", 64'(bus.in_ready), 64'(m_ready));
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            if (m_valid || !reset) begin
                check("result", bus.result, m_out.r);
                check("nzvc", 64'({bus.negative, bus.zero, bus.overflow, bus.carry_out}),
                      64'({m_out.n, m_out.z, m_out.v, m_out.c}));
            end
            if (reset) begin
                if (bus.in_valid && m_ready) begin
                    vectors++;
                    if (bus.cntrl == 3'd7) begin
                        m_valid = 1'b0;
                        m_busy  = W;
                        m_pend  = model(bus.cntrl, bus.A, bus.B);
                    end else begin
                        m_valid = 1'b1;
                        m_out   = model(bus.cntrl, bus.A, bus.B);
                    end
                end else if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_valid = 1'b1;
                        m_out   = m_pend;
                    end
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one op from posedge+1 until accepted; returns at posedge+1 after the accept edge.
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.cntrl    = op;
        bus.A        = a;
        bus.B        = b;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    // Check the result visible in the cycle after the accept edge, then realign.
    task automatic expect_lit(input string name, input logic [63:0] r, input logic [3:0] nzvc);
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(name, bus.result, r);
        check({name, "_nzvc"}, 64'({bus.negative, bus.zero, bus.overflow, bus.carry_out}), 64'(nzvc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        int   start;
        logic [63:0] x, y;

        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.A          = '0;
        bus.B          = '0;
        bus.cntrl      = '0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        bus4.A         = '0;
        bus4.B         = '0;
        bus4.cntrl     = '0;

        // Pin the reference model against hand-computed values.
        e = model(3'd2, 64'd1, 64'd1);
        check("pin_add", e.r, 64'd2);
        e = model(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check("pin_add_v", 64'({e.n, e.z, e.v, e.c}), 64'(4'b1010));
        e = model(3'd3, 64'd0, 64'd1);
        check("pin_sub_nzvc", 64'({e.n, e.z, e.v, e.c}), 64'(4'b1000));
        e = model(3'd7, 64'd123456789, 64'd1000);
        check("pin_mul", e.r, 64'd123456789000);

        // Reset held: compare process checks zeroed outputs.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        do_op(3'd2, 64'd1, 64'd1);
        expect_lit("add_1_1", 64'd2, 4'b0000);
        do_op(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        expect_lit("add_ovf", 64'h8000_0000_0000_0000, 4'b1010);
        do_op(3'd3, 64'd5, 64'd5);
        expect_lit("sub_5_5", 64'd0, 4'b0101);
        do_op(3'd3, 64'd0, 64'd1);
        expect_lit("sub_0_1", '1, 4'b1000);
        do_op(3'd1, 64'd1, 64'd63);
        expect_lit("lsl_63", 64'h8000_0000_0000_0000, 4'b1000);
        do_op(3'd1, 64'hDEAD_BEEF, 64'd0);
        expect_lit("lsl_0", 64'hDEAD_BEEF, 4'b0000);
        do_op(3'd0, 64'd7, 64'd0);
        expect_lit("pass_zero", 64'd0, 4'b0100);

        // MUL latency with MUL_STEP=1.
        do_op(3'd7, 64'd123456789, 64'd1000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
        check("mul_latency", 64'(n), 64'd65);
        check("mul_result", bus.result, 64'd123456789000);
        @(posedge clk);
        #1;

        // MUL latency with MUL_STEP=4.
        bus4.in_valid = 1'b1;
        bus4.cntrl    = 3'd7;
        bus4.A        = 64'd123456789;
        bus4.B        = 64'd1000;
        @(negedge clk);
        check("mul4_in_ready", 64'(bus4.in_ready), 64'd1);
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus4.out_valid && n < 200);
        check("mul4_latency", 64'(n), 64'd17);
        check("mul4_result", bus4.result, 64'd123456789000);
        @(posedge clk);
        #1;

        // Full-throughput stream of single-cycle ops.
        start = cyc_cnt;
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 4))
                0: do_op(3'd0, rnd64(), rnd64());
                1: do_op(3'd1, rnd64(), 64'($urandom_range(0, 63)));
                2: do_op(3'd4, rnd64(), rnd64());
                3: do_op(3'd5, rnd64(), rnd64());
                default: do_op(3'd6, rnd64(), rnd64());
            endcase
        end
        check("stream_cycles", 64'(cyc_cnt - start), 64'd100);
        @(negedge clk);
        @(posedge clk);
        #1;

        // Backpressure hold.
        bus.out_ready = 1'b0;
        x = rnd64();
        y = rnd64();
        e = model(3'd2, x, y);
        do_op(3'd2, x, y);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_result", bus.result, e.r);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Mixed ops with random backpressure and idle gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            do_op(3'($urandom_range(0, 7)), rnd64(), rnd64());
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;

        // Reset during MUL aborts it.
        do_op(3'd7, rnd64(), rnd64());
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_result", bus.result, 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            check("rst_mul_no_output", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        do_op(3'd2, 64'd40, 64'd2);
        expect_lit("add_after_reset", 64'd42, 4'b0000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
